// File: rtl/logic_func_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfu_pkg
//  Description : Shared definitions for the logic function unit. Provides the
//                4-bit truth-table code type, named function codes and the
//                truth-table index helper. The result bit for operand bits
//                x_i, y_i is func[{x_i, y_i}], i.e. index 2*x + y.
//  Revision    : 1.0  initial release
// ============================================================================
package lfu_pkg;

  typedef logic [3:0] lfu_func_t;

  localparam lfu_func_t FN_ZERO    = 4'b0000;
  localparam lfu_func_t FN_NOR     = 4'b0001;
  localparam lfu_func_t FN_AND     = 4'b1000;
  localparam lfu_func_t FN_XOR     = 4'b0110;
  localparam lfu_func_t FN_NAND    = 4'b0111;
  localparam lfu_func_t FN_OR      = 4'b1110;
  localparam lfu_func_t FN_XNOR    = 4'b1001;
  localparam lfu_func_t FN_IMPL_YX = 4'b1101;  // x | ~y
  localparam lfu_func_t FN_ONE     = 4'b1111;

  // Truth-table row selected by one pair of operand bits.
  function automatic logic [1:0] lfu_tt_index(input logic x_bit, input logic y_bit);
    return {x_bit, y_bit};
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_func_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : lfu_if
//  Description : Handshake/data bundle of the logic function unit.
//                Input side : in_valid, in_ready, func, acc_mode, acc_clr, x, y
//                Output side: out_valid, out_ready, r
//                op_count exists only when LFU_OPCOUNT_EN is defined.
//                master = producer/consumer side, slave = the unit itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface lfu_if
  import lfu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  lfu_func_t        func;
  logic             acc_mode;
  logic             acc_clr;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
`ifdef LFU_OPCOUNT_EN
  logic [CNT_W-1:0] op_count;
`endif

  modport master (
`ifdef LFU_OPCOUNT_EN
    input  op_count,
`endif
    output in_valid, func, acc_mode, acc_clr, x, y, out_ready,
    input  in_ready, out_valid, r
  );

  modport slave (
`ifdef LFU_OPCOUNT_EN
    output op_count,
`endif
    input  in_valid, func, acc_mode, acc_clr, x, y, out_ready,
    output in_ready, out_valid, r
  );

endinterface
`default_nettype wire

// File: rtl/logic_func_unit_bitcell.sv
`default_nettype none
// ============================================================================
//  Module      : lfu_bitcell
//  Description : Combinational single-bit cell: selects one truth-table entry
//                of func using the operand bit pair {x_i, y_i}.
//  Ports       : func (4) truth table, x_i/y_i operand bits, r_o result bit.
//  Revision    : 1.0  initial release
// ============================================================================
module lfu_bitcell
  import lfu_pkg::*;
(
  input  lfu_func_t func,
  input  logic      x_i,
  input  logic      y_i,
  output logic      r_o
);

  assign r_o = func[lfu_tt_index(x_i, y_i)];

endmodule
`default_nettype wire

// File: rtl/logic_func_unit.sv
`default_nettype none
// ============================================================================
//  Module      : logic_func_unit
//  Description : Registered two-operand bitwise logic unit. Any of the 16
//                two-input boolean functions (4-bit truth table) is applied
//                per bit across WIDTH bits. valid/ready on both sides, a
//                one-entry output register and an accumulate mode where the
//                x operand is the previous result.
//  Ports       : clk, reset (sync, active-high), bus (lfu_if.slave).
//  Options     : LFU_OPCOUNT_EN adds op_count, a wrapping count of accepts.
//  Revision    : 1.0  initial release
// ============================================================================
module logic_func_unit
  import lfu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
)(
  input  logic   clk,
  input  logic   reset,
  lfu_if.slave   bus
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("logic_func_unit: WIDTH and CNT_W must be >= 1");
  end

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] x_op;
  logic [WIDTH-1:0] result;
  logic             accept;

  // Backpressure passes straight through; nothing is accepted during reset.
  assign bus.in_ready = !reset && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Clear takes effect on the operand in the same cycle it is asserted.
  assign acc_eff = bus.acc_clr ? '0 : acc_q;
  assign x_op    = bus.acc_mode ? acc_eff : bus.x;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    lfu_bitcell u_cell (
      .func (bus.func),
      .x_i  (x_op[i]),
      .y_i  (bus.y[i]),
      .r_o  (result[i])
    );
  end

  always_comb begin
    out_valid_d = out_valid_q;
    r_d         = r_q;
    acc_d       = acc_q;
    if (accept) begin
      r_d         = result;
      out_valid_d = 1'b1;
      acc_d       = result;  // a new result overrides a simultaneous clear
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      if (bus.acc_clr) begin
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.r         = r_q;

`ifdef LFU_OPCOUNT_EN
  logic [CNT_W-1:0] op_count_q, op_count_d;

  // Free-running wrap; acc_clr deliberately has no effect here.
  always_comb begin
    op_count_d = op_count_q;
    if (accept) begin
      op_count_d = op_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign bus.op_count = op_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_func_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_func_unit
//  Description : Scoreboard testbench for logic_func_unit (WIDTH=8, CNT_W=4).
//                Stimulus pushes expected results; a negedge monitor pops
//                and compares whenever a result is consumed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_logic_func_unit;
  import lfu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lfu_if #(.WIDTH(8), .CNT_W(4)) bus ();

  logic_func_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [7:0] exp_q[$];
  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Monitor: every consumed result must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: got r=%0h with no expected entry at %0t", bus.r, $time);
      end else begin
        chk("sb_result", {24'd0, bus.r}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Drive one operation held for one edge; assumes it is accepted there.
  task automatic issue(input logic [3:0] f, input logic [7:0] xv, input logic [7:0] yv,
                       input logic am, input logic ac, input logic [7:0] req, input bit do_push);
    bus.in_valid = 1'b1; bus.func = f; bus.x = xv; bus.y = yv;
    bus.acc_mode = am;   bus.acc_clr = ac;
    if (do_push) exp_q.push_back(req);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.acc_mode = 1'b0; bus.acc_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.func = FN_ZERO; bus.acc_mode = 1'b0; bus.acc_clr = 1'b0;
    bus.x = '0; bus.y = '0; bus.out_ready = 1'b1;

    // Reset state
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_r", {24'd0, bus.r}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
`ifdef LFU_OPCOUNT_EN
    chk("rst_op_count", {28'd0, bus.op_count}, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    // All 16 functions: with x=CC, y=AA the columns walk rows 3,2,1,0,
    // so r is the truth table written twice.
    for (int f = 0; f < 16; f++) begin
      logic [3:0] fv;
      fv = f[3:0];
      issue(fv, 8'hCC, 8'hAA, 1'b0, 1'b0, {fv, fv}, 1'b1);
      if (fv == FN_IMPL_YX) chk("impl_yx", {24'd0, bus.r}, 32'h0000_00DD);
    end
    @(posedge clk); #1;  // drain

    // Backpressure: hold FF for 3 cycles while another op waits
    bus.out_ready = 1'b0;
    issue(FN_OR, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'hFF, 1'b1);
    bus.in_valid = 1'b1; bus.func = FN_AND; bus.x = 8'hFF; bus.y = 8'h0F;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_r", {24'd0, bus.r}, 32'h0000_00FF);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      bus.func = FN_ZERO;  // func changes while held must not matter
    end
    bus.func = FN_AND;
    bus.out_ready = 1'b1;
    exp_q.push_back(8'h0F);
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;  // drain 0F; accumulator now holds 0F

    // Accumulate
    bus.acc_clr = 1'b1;
    @(posedge clk); #1;
    bus.acc_clr = 1'b0;
    chk("clr_keeps_r", {24'd0, bus.r}, 32'h0000_000F);
    issue(FN_XOR, 8'hEE, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1);
    issue(FN_XOR, 8'hEE, 8'h03, 1'b1, 1'b0, 8'h02, 1'b1);
    issue(FN_XOR, 8'hEE, 8'h02, 1'b1, 1'b1, 8'h02, 1'b1);
    issue(FN_XOR, 8'hEE, 8'h00, 1'b1, 1'b0, 8'h02, 1'b1);
    @(posedge clk); #1;

    // Reset while a result is pending and a new op is offered
    bus.out_ready = 1'b0;
    issue(FN_OR, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0);
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("pre_rst_r", {24'd0, bus.r}, 32'h0000_005A);
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.func = FN_OR; bus.x = 8'hFF; bus.y = 8'h00;
    @(negedge clk);
    chk("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; bus.in_valid = 1'b0;
    chk("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mid_r", {24'd0, bus.r}, 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_nothing", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;

`ifdef LFU_OPCOUNT_EN
    chk("cnt_after_rst", {28'd0, bus.op_count}, 32'd0);
    for (int k = 0; k < 17; k++) begin
      logic [7:0] kv;
      kv = k[7:0];
      issue(FN_AND, 8'hFF, kv, 1'b0, 1'b0, kv, 1'b1);
    end
    chk("cnt_wrap", {28'd0, bus.op_count}, 32'd1);
    bus.out_ready = 1'b0;
    issue(FN_AND, 8'hFF, 8'h33, 1'b0, 1'b0, 8'h33, 1'b1);
    bus.in_valid = 1'b1; bus.func = FN_AND; bus.x = 8'hFF; bus.y = 8'h44;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("cnt_stall", {28'd0, bus.op_count}, 32'd2);
    bus.out_ready = 1'b1;
    exp_q.push_back(8'h44);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("cnt_resume", {28'd0, bus.op_count}, 32'd3);
    @(posedge clk); #1;
`endif

    // Throughput: 10 back-to-back ops, out_valid high on every cycle
    for (int k = 0; k < 10; k++) begin
      logic [7:0] kv;
      kv = 8'(k * 17);
      issue(FN_XOR, kv, 8'h0F, 1'b0, 1'b0, kv ^ 8'h0F, 1'b1);
      chk("tp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logic_func_unit.md
Name: logic_func_unit

Overview:
- Parametrised, registered two-operand bitwise logic unit.
- Any of the 16 two-input boolean functions is chosen at run time by a 4-bit truth-table code and applied per bit across WIDTH bits.
- Adds valid/ready handshakes, a one-entry output register and an accumulate mode (x operand taken from the previous result).
- Sits in the gate-level functions library as the general, clocked form of the fixed single-bit function blocks.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 16, width of operation counter (only with LFU_OPCOUNT_EN).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/function presented.
- in_ready  output  1  unit can accept this cycle.
- func  input  4  truth table; result bit = func[{x_i,y_i}] (index 2*x+y).
- acc_mode  input  1  1: x operand is accumulator, x input ignored.
- acc_clr  input  1  clears accumulator.
- x  input  WIDTH  operand x.
- y  input  WIDTH  operand y.
- out_valid  output  1  r holds an unconsumed result.
- out_ready  input  1  consumer takes r this cycle.
- r  output  WIDTH  registered result.
- op_count  output  CNT_W  accepted-operation count (LFU_OPCOUNT_EN only).

Behaviour:
- Reset (clk edge with reset=1): out_valid=0, r=0, accumulator=0, op_count=0. Reset overrides every simultaneous input, including a mid-handshake transfer; the pending result is discarded.
- in_ready = !out_valid || out_ready (combinational, pass-through of backpressure). in_ready is 0 during reset cycles.
- Accept = in_valid && in_ready.
- On accept:
  - r <= F(xo, y) bitwise, with xo = acc_mode ? acc_eff : x.
  - out_valid <= 1.
  - acc <= new r.
- Latency: exactly one cycle from accept to out_valid. Full throughput: one op per cycle when out_ready is held 1.
- Output drain: out_valid && out_ready && !accept -> out_valid <= 0, r holds its value.
- Output hold: out_valid=1 && out_ready=0 -> r, out_valid stable; in_ready=0; no input consumed.
- acc_eff = acc_clr ? 0 : acc. acc_clr clears before use in the same cycle.
- acc_clr without accept: acc <= 0; r, out_valid unaffected.
- acc_clr with accept: acc loads the new result (load wins over clear).
- func is sampled only on accept. Changes while out_valid is held do not alter r.
- Constant functions: func=0000 gives all zeros; func=1111 gives all ones, independent of operands.
- Purely synchronous; no combinational path from x/y/func to r.

Optional Feature:
- Macro LFU_OPCOUNT_EN.
- Defined:
  - op_count port present.
  - Increments by 1 on each accept.
  - Wraps from 2^CNT_W-1 to 0 with no saturation or flag.
  - Cleared only by reset; acc_clr does not affect it.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package (lfu_pkg):
  - Named 4-bit function codes: FN_ZERO=0000, FN_NOR=0001, FN_AND=1000, FN_XOR=0110, FN_NAND=0111, FN_OR=1110, FN_XNOR=1001, FN_IMPL_YX=1101 (x|~y), FN_ONE=1111.
  - Truth-table index convention.
- One natural sub-module, lfu_bitcell: combinational single-bit 4:1 select of func by {x_i,y_i}, instantiated WIDTH times via generate. The parent holds all registers and handshake logic.

Test Plan:
- Exhaustive function check: WIDTH=8, x=8'b11001100, y=8'b10101010, out_ready=1, step func 0..15 -> each r equals func replicated per column; func=1101 -> r=8'b11011101.
- Backpressure: accept x=F0,y=0F,func=FN_OR with out_ready=0 for 3 cycles -> r=FF, out_valid=1 and in_ready=0 held throughout. Then out_ready=1 -> new op accepted in that same cycle.
- Accumulate: acc_clr then XOR with acc_mode=1:
  - y=01 -> r=01.
  - y=03 -> r=02.
  - y=02 with acc_clr=1 in the same cycle -> r=02 (clear wins for the operand); accumulator now 02.
- Reset mid-operation: out_valid=1, r=5A, assert reset together with in_valid -> next cycle out_valid=0, r=00, nothing accepted.
- Opcount (LFU_OPCOUNT_EN, CNT_W=4): 17 accepted ops -> op_count=1 (wrap). 2 cycles with in_valid and in_ready=0 -> no increment.
- Throughput: 10 back-to-back ops with out_ready=1 -> 10 consecutive out_valid cycles, each r matching its input one cycle earlier.
